cas_tx_serializer: RTL and testbench

Cassette-output byte serializer for the MC-10 tape path. Accepts bytes over a valid/ready handshake and drives the `freq` select of the downstream cassette square-wave generator, one full square cycle per bit: LSB first, 0 = slow tone, 1 = fast tone. Bit boundaries are taken from rising edges of the generator's own square output, fed back as `sq`, so every bit is exactly one whole tone cycle.

---
 rtl/cas_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_cas_tx_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_tx_serializer.sv
// Cassette-output byte serializer: one full generator square cycle per bit, LSB first.
// Optional feature macro CAS_TX_SYNC_EN: passes sq through a two-flop synchroniser before edge detection.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no byte on the wire, freq held at IDLE_FREQ, waiting on a rise
//   SHIFT | byte in progress, freq carries shr[0], cnt counts bits sent
module cas_tx_serializer #(
    parameter logic IDLE_FREQ = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       sq,
    output logic       freq,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold;
    logic [7:0] hold_nxt;
    logic       hold_full;
    logic       hold_full_nxt;
    logic [7:0] shr;
    logic [7:0] shr_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       freq_nxt;
    logic       done_nxt;
    logic       load;
    logic       sq_s;
    logic       sq_prev;
    logic       rise;

`ifdef CAS_TX_SYNC_EN
    logic [1:0] sq_sync;

    // Reset to 1 to match the generator's reset level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_sync <= 2'b11;
        end else begin
            sq_sync <= {sq_sync[0], sq};
        end
    end

    assign sq_s = sq_sync[1];
`else
    assign sq_s = sq;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_prev <= 1'b1;
        end else begin
            sq_prev <= sq_s;
        end
    end

    assign rise = sq_s & ~sq_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shr       <= 8'h00;
            cnt       <= 3'd0;
            freq      <= IDLE_FREQ;
            byte_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            shr       <= shr_nxt;
            cnt       <= cnt_nxt;
            freq      <= freq_nxt;
            byte_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        shr_nxt       = shr;
        cnt_nxt       = cnt;
        freq_nxt      = freq;
        done_nxt      = 1'b0;
        load          = 1'b0;

        // Accept and load are exclusive: accept needs an empty buffer, load a full one.
        if (in_valid && !hold_full) begin
            hold_nxt      = in_data;
            hold_full_nxt = 1'b1;
        end

        if (rise) begin
            case (state)
                IDLE: begin
                    if (tx_en && hold_full) begin
                        load = 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd7) begin
                        shr_nxt = {1'b0, shr[7:1]};
                        cnt_nxt = cnt + 3'd1;
                    end else begin
                        done_nxt = 1'b1;
                        if (tx_en && hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (load) begin
                shr_nxt       = hold;
                cnt_nxt       = 3'd0;
                hold_full_nxt = 1'b0;
                state_nxt     = SHIFT;
            end

            freq_nxt = (state_nxt == SHIFT) ? shr_nxt[0] : IDLE_FREQ;
        end
    end

    assign in_ready = ~hold_full;
    assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_cas_tx_serializer.sv
// Bench for cas_tx_serializer: plays the square generator and checks the tone sent in each rise-to-rise cycle.
module tb_cas_tx_serializer;

    localparam logic IDLE = 1'b0;
`ifdef CAS_TX_SYNC_EN
    localparam int RL = 2;
`else
    localparam int RL = 0;
`endif

    logic       clk;
    logic       reset;
    logic       tx_en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sq;
    logic       freq;
    logic       busy;
    logic       byte_done;

    int         n_cmp;
    int         n_bad;
    int         done_cnt;
    int         exp_done;
    logic       last_rdy;
    logic [7:0] rb [3];

    cas_tx_serializer dut (
        .clk      (clk),
        .reset    (reset),
        .tx_en    (tx_en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sq       (sq),
        .freq     (freq),
        .busy     (busy),
        .byte_done(byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic tick(output logic f, output logic b, output logic r);
        logic acc;
        @(negedge clk);
        f   = freq;
        b   = busy;
        r   = in_ready;
        acc = in_valid && in_ready;
        if (byte_done) done_cnt++;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
    endtask

    // One tone cycle starting with a rise; optionally offer a byte before clock otick.
    task automatic cycle(input int h, input bit offer, input int otick, input logic [7:0] d,
                         output logic f, output logic b, output logic r);
        logic tf, tb, tr;
        sq = 1'b1;
        for (int t = 0; t < 2 * h; t++) begin
            if (t == h) sq = 1'b0;
            if (offer && t == otick) begin
                in_data  = d;
                in_valid = 1'b1;
            end
            tick(tf, tb, tr);
        end
        f = tf;
        b = tb;
        r = tr;
    endtask

    task automatic exp_cycle(input string tag, input logic ef, input logic eb,
                             input bit offer, input logic [7:0] d, input int otick);
        int   h;
        logic f, b, r;
        h = int'($urandom_range(7, 4));
        cycle(h, offer, (otick < 0) ? h + 1 : otick, d, f, b, r);
        last_rdy = r;
        check($sformatf("%s freq", tag), {7'd0, f}, {7'd0, ef});
        check($sformatf("%s busy", tag), {7'd0, b}, {7'd0, eb});
    endtask

    task automatic idle_cycle(input string tag, input bit offer, input logic [7:0] d, input int otick);
        exp_cycle(tag, IDLE, 1'b0, offer, d, otick);
    endtask

    // Eight cycles carrying bits of b LSB first; optionally offer the next byte during bit 0.
    task automatic exp_byte(input string tag, input logic [7:0] b, input bit offer, input logic [7:0] d);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < 8; i++) begin
            exp_cycle($sformatf("%s bit%0d", tag, i), v[i], 1'b1, offer && (i == 0), d, -1);
        end
    endtask

    initial begin
        logic       f, b, r;
        logic [7:0] x, y, z, w;
        int         nb;
        int         dc;

        n_cmp    = 0;
        n_bad    = 0;
        done_cnt = 0;
        exp_done = 0;
        reset    = 1'b1;
        tx_en    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        sq       = 1'b1;

        tick(f, b, r);
        tick(f, b, r);
        check("reset in_ready", {7'd0, r}, 8'd1);
        check("reset freq", {7'd0, f}, {7'd0, IDLE});
        check("reset busy", {7'd0, b}, 8'd0);
        check("reset byte_done", {7'd0, byte_done}, 8'd0);
        tick(f, b, r);
        reset = 1'b0;
        sq    = 1'b0;
        for (int i = 0; i < 4; i++) tick(f, b, r);

        for (int i = 0; i < 3; i++) begin
            idle_cycle($sformatf("idle%0d", i), 1'b0, 8'h00, -1);
            check($sformatf("idle%0d in_ready", i), {7'd0, last_rdy}, 8'd1);
        end
        check("idle done count", done_cnt[7:0], 8'd0);

        idle_cycle("a5 pre", 1'b1, 8'hA5, -1);
        exp_byte("a5", 8'hA5, 1'b0, 8'h00);
        idle_cycle("a5 post", 1'b0, 8'h00, -1);
        exp_done += 1;
        check("a5 done count", done_cnt[7:0], exp_done[7:0]);
        check("a5 in_ready", {7'd0, last_rdy}, 8'd1);

        idle_cycle("b2b pre", 1'b1, 8'h00, -1);
        exp_byte("b2b 00", 8'h00, 1'b1, 8'hFF);
        exp_byte("b2b ff", 8'hFF, 1'b0, 8'h00);
        idle_cycle("b2b post", 1'b0, 8'h00, -1);
        exp_done += 2;
        check("b2b done count", done_cnt[7:0], exp_done[7:0]);

        x = 8'($urandom);
        idle_cycle("coinc rise", 1'b1, x, RL);
        check("coinc accepted", {7'd0, last_rdy}, 8'd0);
        exp_byte("coinc", x, 1'b0, 8'h00);
        idle_cycle("coinc post", 1'b0, 8'h00, -1);
        exp_done += 1;
        check("coinc done count", done_cnt[7:0], exp_done[7:0]);

        x = 8'($urandom);
        y = 8'($urandom);
        idle_cycle("txen pre", 1'b1, x, -1);
        exp_cycle("txen x bit0", x[0], 1'b1, 1'b1, y, -1);
        exp_cycle("txen x bit1", x[1], 1'b1, 1'b0, 8'h00, -1);
        exp_cycle("txen x bit2", x[2], 1'b1, 1'b0, 8'h00, -1);
        tx_en = 1'b0;
        for (int i = 3; i < 8; i++) begin
            exp_cycle($sformatf("txen x bit%0d", i), x[i], 1'b1, 1'b0, 8'h00, -1);
        end
        for (int i = 0; i < 2; i++) begin
            idle_cycle($sformatf("txen hold%0d", i), 1'b0, 8'h00, -1);
            check($sformatf("txen hold%0d in_ready", i), {7'd0, last_rdy}, 8'd0);
        end
        exp_done += 1;
        check("txen done count", done_cnt[7:0], exp_done[7:0]);
        tx_en = 1'b1;
        exp_byte("txen y", y, 1'b0, 8'h00);
        idle_cycle("txen post", 1'b0, 8'h00, -1);
        exp_done += 1;
        check("txen y done count", done_cnt[7:0], exp_done[7:0]);
        check("txen in_ready", {7'd0, last_rdy}, 8'd1);

        for (int k = 0; k < 3; k++) begin
            nb = int'($urandom_range(3, 1));
            for (int i = 0; i < 3; i++) rb[i] = 8'($urandom);
            idle_cycle($sformatf("rnd%0d pre", k), 1'b1, rb[0], -1);
            for (int i = 0; i < nb; i++) begin
                exp_byte($sformatf("rnd%0d b%0d", k, i), rb[i], (i + 1) < nb, rb[(i + 1) % 3]);
            end
            idle_cycle($sformatf("rnd%0d post", k), 1'b0, 8'h00, -1);
            exp_done += nb;
            check($sformatf("rnd%0d done count", k), done_cnt[7:0], exp_done[7:0]);
        end

        z = 8'($urandom);
        w = 8'($urandom);
        idle_cycle("rst pre", 1'b1, z, -1);
        exp_cycle("rst z bit0", z[0], 1'b1, 1'b1, w, -1);
        for (int i = 1; i < 5; i++) begin
            exp_cycle($sformatf("rst z bit%0d", i), z[i], 1'b1, 1'b0, 8'h00, -1);
        end
        sq = 1'b1;
        tick(f, b, r);
        tick(f, b, r);
        reset = 1'b1;
        tick(f, b, r);
        tick(f, b, r);
        check("rst freq", {7'd0, f}, {7'd0, IDLE});
        check("rst busy", {7'd0, b}, 8'd0);
        check("rst in_ready", {7'd0, r}, 8'd1);
        check("rst byte_done", {7'd0, byte_done}, 8'd0);
        reset = 1'b0;
        dc    = done_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) sq = 1'b0;
            tick(f, b, r);
        end
        for (int i = 0; i < 2; i++) begin
            idle_cycle($sformatf("rst idle%0d", i), 1'b0, 8'h00, -1);
            check($sformatf("rst idle%0d in_ready", i), {7'd0, last_rdy}, 8'd1);
        end
        check("rst no byte_done", done_cnt[7:0], dc[7:0]);
        exp_done = dc;

        x = 8'($urandom);
        idle_cycle("recover pre", 1'b1, x, -1);
        exp_byte("recover", x, 1'b0, 8'h00);
        idle_cycle("recover post", 1'b0, 8'h00, -1);
        exp_done += 1;
        check("recover done count", done_cnt[7:0], exp_done[7:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
